// File: rtl/logic_issue_ctrl_if.sv
// Bus bundle between the issue stage, the LOGIC execution unit and writeback.
// Handshake semantics (req_* and wb_*): a transfer happens on a rising clock
// edge where valid and ready are both high; the sender holds its payload
// stable while valid is high and ready is low, and ready never depends on
// the transfer it is about to accept.
interface logic_issue_ctrl_if #(
  parameter int RD_W = 5
) ();
  // Issue stage -> controller
  logic            req_valid;
  logic            req_ready;
  logic [31:0]     req_op1;
  logic [31:0]     req_op2;
  logic [1:0]      req_mode1;
  logic [2:0]      req_mode2;
  logic [RD_W-1:0] req_rd;
  // Controller <-> LOGIC unit
  logic            lu_start;
  logic [1:0]      lu_use_part;
  logic [31:0]     lu_op1;
  logic [31:0]     lu_op2;
  logic [1:0]      lu_mode1;
  logic [2:0]      lu_mode2;
  logic            lu_done;
  logic [31:0]     lu_res;
  // Controller -> writeback
  logic            wb_valid;
  logic            wb_ready;
  logic [RD_W-1:0] wb_rd;
  logic [31:0]     wb_data;
  logic            wb_err;

  // Environment side: issue stage, LOGIC unit and writeback together.
  modport master (
    output req_valid, req_op1, req_op2, req_mode1, req_mode2, req_rd,
    input  req_ready,
    input  lu_start, lu_use_part, lu_op1, lu_op2, lu_mode1, lu_mode2,
    output lu_done, lu_res,
    input  wb_valid, wb_rd, wb_data, wb_err,
    output wb_ready
  );

  // Controller side.
  modport slave (
    input  req_valid, req_op1, req_op2, req_mode1, req_mode2, req_rd,
    output req_ready,
    output lu_start, lu_use_part, lu_op1, lu_op2, lu_mode1, lu_mode2,
    input  lu_done, lu_res,
    output wb_valid, wb_rd, wb_data, wb_err,
    input  wb_ready
  );
endinterface

// File: rtl/logic_issue_ctrl.sv
// Issue/writeback sequencer in front of the LOGIC execution unit.
// Requests are buffered in a small FIFO, issued one at a time with a single
// start pulse, and the unit's result (or a timeout error) is held on the
// writeback port until accepted. flush empties everything synchronously.
module logic_issue_ctrl #(
  parameter int         FIFO_DEPTH = 2,
  parameter int         TIMEOUT    = 15,
  parameter logic [1:0] USE_PART   = 2'b00,
  parameter int         RD_W       = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  logic_issue_ctrl_if.slave  bus,
  output logic               busy,
  output logic [1:0]         dbg_state
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int EW = 32 + 32 + 2 + 3 + RD_W;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_WB    = 2'd3
  } state_t;

  state_t          state;
  state_t          state_nxt;

  logic [EW-1:0]   mem [FIFO_DEPTH];
  logic [EW-1:0]   wr_data;
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic            full;
  logic            empty;
  logic            push;
  logic            pop;
  logic            req_ready_int;

  logic [31:0]     op1_q;
  logic [31:0]     op2_q;
  logic [1:0]      mode1_q;
  logic [2:0]      mode2_q;
  logic [RD_W-1:0] rd_hold;
  logic [TW-1:0]   timer;
  logic [31:0]     wb_data_q;
  logic            wb_err_q;
  logic            timed_out;

  assign full          = (count == CW'(FIFO_DEPTH));
  assign empty         = (count == '0);
  // Gated by rst so the ready output is low for the whole reset period.
  assign req_ready_int = rst && !full && !flush;
  assign push          = bus.req_valid && req_ready_int;
  // No bypass: only an entry already stored at this edge can be popped.
  assign pop           = (state == S_IDLE) && !empty && !flush;
  assign timed_out     = (timer == TW'(TIMEOUT - 1));
  assign wr_data       = {bus.req_op1, bus.req_op2, bus.req_mode1,
                          bus.req_mode2, bus.req_rd};

  // FIFO storage; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // FIFO pointers and occupancy; flush discards all buffered entries.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next state; flush overrides every transition.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (pop) state_nxt = S_ISSUE;
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT:  if (bus.lu_done || timed_out) state_nxt = S_WB;
      S_WB:    if (bus.wb_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (flush) state_nxt = S_IDLE;
  end

  // Operand capture at pop, WAIT timer, and result capture for writeback.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op1_q     <= '0;
      op2_q     <= '0;
      mode1_q   <= '0;
      mode2_q   <= '0;
      rd_hold   <= '0;
      timer     <= '0;
      wb_data_q <= '0;
      wb_err_q  <= 1'b0;
    end else if (flush) begin
      timer <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pop) begin
            {op1_q, op2_q, mode1_q, mode2_q, rd_hold} <= mem[rd_ptr];
          end
        end
        S_ISSUE: begin
          timer <= '0;
        end
        S_WAIT: begin
          if (bus.lu_done) begin
            wb_data_q <= bus.lu_res;
            wb_err_q  <= 1'b0;
          end else if (timed_out) begin
            wb_data_q <= '0;
            wb_err_q  <= 1'b1;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        default: begin
          timer <= timer;
        end
      endcase
    end
  end

  assign bus.req_ready   = req_ready_int;
  assign bus.lu_start    = (state == S_ISSUE) && !flush;
  assign bus.lu_use_part = rst ? USE_PART : 2'b00;
  assign bus.lu_op1      = op1_q;
  assign bus.lu_op2      = op2_q;
  assign bus.lu_mode1    = mode1_q;
  assign bus.lu_mode2    = mode2_q;
  assign bus.wb_valid    = (state == S_WB);
  assign bus.wb_rd       = rd_hold;
  assign bus.wb_data     = wb_data_q;
  assign bus.wb_err      = wb_err_q;
  assign busy            = (state != S_IDLE) || !empty;
  assign dbg_state       = state;

endmodule

// File: doc/logic_issue_ctrl.md
Name: logic_issue_ctrl

Overview:
- Issue/writeback sequencer directly upstream of the LOGIC execution unit.
- Buffers decoded logic-class requests from the issue stage and drives the unit's operand/mode/start interface.
- Waits for the unit's done and returns the tagged result to writeback over a valid/ready handshake.
- Adds timeout protection and pipeline flush.

Parameters:
FIFO_DEPTH, 2, request buffer entries (power of 2, ≥2)
TIMEOUT, 15, max WAIT cycles before the request is abandoned (≥2)
USE_PART, 2'b00, constant value driven on lu_use_part
RD_W, 5, destination register tag width

Ports:
clk  input  1  single clock, rising edge
rst  input  1  reset, asynchronous, active-low
flush  input  1  synchronous pipeline flush
req_valid  input  1  request present
req_ready  output  1  request accepted when both high
req_op1  input  32  operand 1
req_op2  input  32  operand 2
req_mode1  input  2  op_mode1 for unit
req_mode2  input  3  op_mode2 for unit
req_rd  input  RD_W  destination tag
lu_start  output  1  one-cycle start pulse to LOGIC unit
lu_use_part  output  2  part select (=USE_PART)
lu_op1  output  32  operand 1 to unit, held from ISSUE until next pop
lu_op2  output  32  operand 2 to unit
lu_mode1  output  2  mode 1 to unit
lu_mode2  output  3  mode 2 to unit
lu_done  input  1  unit completion
lu_res  input  32  unit result, valid with lu_done
wb_valid  output  1  result present
wb_ready  input  1  writeback accepts
wb_rd  output  RD_W  destination tag
wb_data  output  32  result
wb_err  output  1  result abandoned by timeout
busy  output  1  state≠IDLE or FIFO non-empty

Behaviour:
- Reset (rst=0, async): FIFO empty, state IDLE, every output 0 (incl. req_ready, lu_*, wb_*, busy); timer 0. Reset mid-operation discards everything; late lu_done ignored.
- req_ready = !full && !flush. Push on req_valid&&req_ready. No bypass: a pop needs count≥1 at the clock edge.
- Request order preserved (FIFO). Count range 0..FIFO_DEPTH. Pointers wrap modulo FIFO_DEPTH.
- FSM:
  - IDLE: if !empty && !flush, pop head into lu_op1/op2/mode1/mode2 and rd_hold; go ISSUE.
  - ISSUE: lu_start=1 for exactly this cycle; timer←0; go WAIT.
  - WAIT: lu_done=1 → wb_data←lu_res, wb_err←0, go WB. Else timer++. When timer==TIMEOUT-1 with no done → wb_data←0, wb_err←1, go WB.
  - WB: wb_valid=1. wb_rd/wb_data/wb_err stay stable until wb_ready. On handshake go IDLE.
- lu_done is sampled only in WAIT; it is ignored in IDLE/ISSUE/WB.
- Latency, 1-cycle unit, empty FIFO:
  - req handshake in cycle 0
  - IDLE pop in cycle 1
  - lu_start in cycle 2
  - lu_done in cycle 3
  - wb_valid in cycle 4
- Throughput: one request per (4 + unit latency − 1 + wb stall) cycles.
- flush (synchronous, priority over everything but reset):
  - FIFO emptied; state→IDLE; wb_valid→0 next cycle.
  - No lu_start in the flush cycle.
  - Pending unit result is dropped.
  - A push coinciding with flush is refused (req_ready=0).
- lu_use_part constant USE_PART; lu_* operand outputs hold their last value outside ISSUE/WAIT.

Test Plan:
- Single op: req op1=0xF0F00000, op2=0x0FF0FFFF, rd=7; stub asserts lu_done one cycle after lu_start with lu_res=0xFFF0FFFF → exactly one lu_start; wb_valid 4 cycles after acceptance; wb_rd=7, wb_data=0xFFF0FFFF, wb_err=0.
- Backpressure/full: wb_ready=0; offer rd=1,2,3,4 back-to-back → req_ready drops after rd=3 accepted (1 in flight + 2 buffered); then release wb_ready → wb_rd sequence 1,2,3, then 4 after re-offer; no lu_start while in WB.
- Timeout: never assert lu_done → wb_valid after 15 WAIT cycles; wb_data=0, wb_err=1; next request proceeds normally.
- WB stall stability: hold wb_ready=0 for 5 cycles → wb_rd/wb_data/wb_err unchanged each cycle; handshake on cycle 6 → state IDLE next cycle.
- Flush in WAIT with 1 buffered request, then lu_done one cycle later → no wb_valid; busy=0 the cycle after flush; no lu_start.
- Async reset: drop rst mid-WAIT between clock edges → all outputs 0 immediately; after release, req_ready=1 at first clock and a fresh request completes per scenario 1.
